// File: rtl/traffic_light_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_light_sequencer
//
// Light-phase controller on the far side of the phase timer handshake. It
// watches the timer's go-yellow (i_nextLight) and phase-done (i_newState)
// levels, sequences the north-south / east-west lamps through
// green -> yellow -> all-red, and inserts a pedestrian walk interval (framed
// by all-red on both sides) whenever a button press has been latched.
//
// Ports
//   i_clk          system clock
//   i_nreset       asynchronous reset, active-high (1 = in reset)
//   i_newState     timer phase-done level, rising edge used
//   i_nextLight    timer go-yellow level, rising edge used
//   i_pedRequest   asynchronous pedestrian push-button, active-high
//   o_countEnable  lets the timer advance (low only during all-red)
//   o_nsLights     north-south lamps {red, yellow, green}
//   o_ewLights     east-west lamps {red, yellow, green}
//   o_pedWalk      pedestrian WALK lamp
//   o_pedWaiting   a pedestrian request is latched and not yet served
//   o_phase        current state code, for debug
//
// State table
//   state     | code | meaning
//   NS_GREEN  |  0   | NS green, EW red, timer running
//   NS_YELLOW |  1   | NS yellow, EW red, waiting for phase-done
//   ALL_RED   |  2   | both red for ALLRED_CYCLES, timer held
//   EW_GREEN  |  3   | EW green, NS red, timer running
//   EW_YELLOW |  4   | EW yellow, NS red, waiting for phase-done
//   PED_WALK  |  5   | both red, WALK lit until the go-yellow edge
//   (6, 7)    |  -   | illegal, recovers to ALL_RED
// -----------------------------------------------------------------------------
module traffic_light_sequencer #(
   parameter int ALLRED_CYCLES = 50000000,
   parameter int CNT_W         = 26
) (
   input  logic       i_clk,
   input  logic       i_nreset,
   input  logic       i_newState,
   input  logic       i_nextLight,
   input  logic       i_pedRequest,
   output logic       o_countEnable,
   output logic [2:0] o_nsLights,
   output logic [2:0] o_ewLights,
   output logic       o_pedWalk,
   output logic       o_pedWaiting,
   output logic [2:0] o_phase
);

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED   = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      PED_WALK  = 3'd5
   } state_e;

   typedef enum logic {
      DIR_NS = 1'b0,
      DIR_EW = 1'b1
   } dir_e;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYCLES - 1);

   state_e           state_q, state_d;
   dir_e             dir_q, dir_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ped_latch_q, ped_latch_d;
   logic             walk_done_q, walk_done_d;

   logic             new_prev_q;
   logic             next_prev_q;
   logic             ped_sync1_q;
   logic             ped_sync2_q;
   logic             ped_prev_q;

   logic             new_rise;
   logic             next_rise;
   logic             ped_rise;
   logic             entering_walk;

   // ---------------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------------
   // The timer levels come from the same clock domain, so a single history
   // flop is enough. A level that is already high when a state is entered has
   // a high history bit and therefore yields no edge.
   assign new_rise  = i_newState  & ~new_prev_q;
   assign next_rise = i_nextLight & ~next_prev_q;

   // The push-button is asynchronous: two-flop synchronizer, then edge detect
   // on the synchronized copy.
   assign ped_rise  = ped_sync2_q & ~ped_prev_q;

   always_ff @(posedge i_clk or posedge i_nreset) begin
      if (i_nreset) begin
         new_prev_q  <= 1'b0;
         next_prev_q <= 1'b0;
         ped_sync1_q <= 1'b0;
         ped_sync2_q <= 1'b0;
         ped_prev_q  <= 1'b0;
      end else begin
         new_prev_q  <= i_newState;
         next_prev_q <= i_nextLight;
         ped_sync1_q <= i_pedRequest;
         ped_sync2_q <= ped_sync1_q;
         ped_prev_q  <= ped_sync2_q;
      end
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_nreset) begin
      if (i_nreset) begin
         state_q     <= ALL_RED;
         dir_q       <= DIR_NS;
         cnt_q       <= '0;
         ped_latch_q <= 1'b0;
         walk_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         cnt_q       <= cnt_d;
         ped_latch_q <= ped_latch_d;
         walk_done_q <= walk_done_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // The all-red counter is held at zero outside ALL_RED, so every entry
   // starts counting from zero without a separate entry pulse.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = '0;

      case (state_q)
         NS_GREEN: begin
            if (new_rise || next_rise) begin
               state_d = NS_YELLOW;
            end
         end

         NS_YELLOW: begin
            if (new_rise) begin
               state_d = ALL_RED;
               dir_d   = DIR_EW;
            end
         end

         EW_GREEN: begin
            if (new_rise || next_rise) begin
               state_d = EW_YELLOW;
            end
         end

         EW_YELLOW: begin
            if (new_rise) begin
               state_d = ALL_RED;
               dir_d   = DIR_NS;
            end
         end

         ALL_RED: begin
            if (cnt_q == ALLRED_LAST) begin
               // A press detected on the very last all-red cycle still wins
               // this exit, even though the latch only shows it next cycle.
               if (ped_latch_q || ped_rise) begin
                  state_d = PED_WALK;
               end else if (dir_q == DIR_EW) begin
                  state_d = EW_GREEN;
               end else begin
                  state_d = NS_GREEN;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         PED_WALK: begin
            // Direction is left alone so the green that was due before the
            // walk follows the second all-red.
            if (new_rise) begin
               state_d = ALL_RED;
            end
         end

         default: begin
            state_d = ALL_RED;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Pedestrian latch and walk lamp
   // ---------------------------------------------------------------------------
   assign entering_walk = (state_d == PED_WALK) && (state_q != PED_WALK);

   always_comb begin
      ped_latch_d = ped_latch_q;
      if (entering_walk) begin
         ped_latch_d = 1'b0;
      end else if (ped_rise && (state_q != PED_WALK)) begin
         ped_latch_d = 1'b1;
      end
   end

   // WALK stays lit until the first go-yellow edge seen inside PED_WALK; the
   // flag is forced low everywhere else so each walk starts lit.
   always_comb begin
      walk_done_d = 1'b0;
      if (state_q == PED_WALK) begin
         walk_done_d = walk_done_q | next_rise;
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode (from the state register only)
   // ---------------------------------------------------------------------------
   always_comb begin
      o_nsLights    = LAMP_RED;
      o_ewLights    = LAMP_RED;
      o_countEnable = 1'b0;
      o_pedWalk     = 1'b0;

      case (state_q)
         NS_GREEN: begin
            o_nsLights    = LAMP_GREEN;
            o_countEnable = 1'b1;
         end
         NS_YELLOW: begin
            o_nsLights    = LAMP_YELLOW;
            o_countEnable = 1'b1;
         end
         EW_GREEN: begin
            o_ewLights    = LAMP_GREEN;
            o_countEnable = 1'b1;
         end
         EW_YELLOW: begin
            o_ewLights    = LAMP_YELLOW;
            o_countEnable = 1'b1;
         end
         PED_WALK: begin
            o_countEnable = 1'b1;
            o_pedWalk     = ~walk_done_q;
         end
         default: begin
            o_nsLights    = LAMP_RED;
            o_ewLights    = LAMP_RED;
            o_countEnable = 1'b0;
            o_pedWalk     = 1'b0;
         end
      endcase
   end

   assign o_pedWaiting = ped_latch_q;
   assign o_phase      = state_q;

   // Safety properties: never two non-red directions, never WALK over traffic.
   a_no_conflict: assert property (@(posedge i_clk) disable iff (i_nreset)
      (o_nsLights == LAMP_RED) || (o_ewLights == LAMP_RED));

   a_walk_all_red: assert property (@(posedge i_clk) disable iff (i_nreset)
      !o_pedWalk || ((o_nsLights == LAMP_RED) && (o_ewLights == LAMP_RED)));

endmodule

// File: tb/tb_traffic_light_sequencer.sv
module tb_traffic_light_sequencer;

   localparam int ALLRED = 4;
   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   logic       clk        = 1'b0;
   logic       rst        = 1'b0;
   logic       new_state  = 1'b0;
   logic       next_light = 1'b0;
   logic       ped_req    = 1'b0;
   logic       ce;
   logic [2:0] ns;
   logic [2:0] ew;
   logic       walk;
   logic       waiting;
   logic [2:0] phase;

   int n_checks = 0;
   int n_pass   = 0;
   int inv_viol = 0;
   int ce_viol  = 0;
   bit timer_on = 1'b0;
   int tcnt     = 0;

   typedef enum int {ACT_NONE, ACT_PED, ACT_WALK, ACT_PED_IGNORE} act_e;

   typedef struct {
      string      name;
      int         ph;
      logic [2:0] ns;
      logic [2:0] ew;
      logic       ce;
      logic       waiting;
      logic       walk;
      int         dwell;
      act_e       act;
   } row_t;

   row_t rows[$];

   traffic_light_sequencer #(
      .ALLRED_CYCLES (ALLRED),
      .CNT_W         (3)
   ) dut (
      .i_clk         (clk),
      .i_nreset      (rst),
      .i_newState    (new_state),
      .i_nextLight   (next_light),
      .i_pedRequest  (ped_req),
      .o_countEnable (ce),
      .o_nsLights    (ns),
      .o_ewLights    (ew),
      .o_pedWalk     (walk),
      .o_pedWaiting  (waiting),
      .o_phase       (phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic add(input string nm, input int ph, input logic [2:0] n, input logic [2:0] e,
                      input logic c, input logic w, input logic wk, input int dw, input act_e a);
      row_t r;
      r.name = nm; r.ph = ph; r.ns = n; r.ew = e; r.ce = c;
      r.waiting = w; r.walk = wk; r.dwell = dw; r.act = a;
      rows.push_back(r);
   endtask

   task automatic wait_change(input string name);
      logic [2:0] cur;
      int n;
      cur = phase;
      n = 0;
      while (phase == cur && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({name, "_reached"}, int'(phase != cur), 1);
   endtask

   // Counts consecutive negedge samples (including the current one) in the
   // present phase; returns on the first sample of the following phase.
   task automatic dwell(output int n);
      logic [2:0] cur;
      cur = phase;
      n = 0;
      while (phase == cur && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Timer model: counts enabled clocks; go-yellow at 6 ticks, phase-done
   // pulse at 8 ticks (tick = 10 clk), then restarts.
   initial begin
      forever begin
         @(negedge clk);
         if (timer_on) begin
            new_state = 1'b0;
            if (ce) begin
               tcnt++;
               if (tcnt == 60) next_light = 1'b1;
               if (tcnt == 80) begin
                  new_state  = 1'b1;
                  next_light = 1'b0;
                  tcnt       = 0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (ns != R && ew != R) inv_viol++;
      if (walk && !(ns == R && ew == R)) inv_viol++;
      if (ce != (phase != 3'd2)) ce_viol++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      bit changed;

      add("ns_green0",  0, G, R, 1, 0, 0, 0,      ACT_NONE);
      add("ns_yellow0", 1, Y, R, 1, 0, 0, 0,      ACT_NONE);
      add("allred0",    2, R, R, 0, 0, 0, ALLRED, ACT_NONE);
      add("ew_green0",  3, R, G, 1, 0, 0, 0,      ACT_NONE);
      add("ew_yellow0", 4, R, Y, 1, 0, 0, 0,      ACT_NONE);
      add("allred1",    2, R, R, 0, 0, 0, ALLRED, ACT_NONE);
      add("ns_green1",  0, G, R, 1, 0, 0, 0,      ACT_PED);
      add("ns_yellow1", 1, Y, R, 1, 1, 0, 0,      ACT_NONE);
      add("allred2",    2, R, R, 0, 1, 0, ALLRED, ACT_NONE);
      add("ped_walk0",  5, R, R, 1, 0, 1, 0,      ACT_WALK);
      add("allred3",    2, R, R, 0, 0, 0, ALLRED, ACT_NONE);
      add("ew_green1",  3, R, G, 1, 0, 0, 0,      ACT_NONE);
      add("ew_yellow1", 4, R, Y, 1, 0, 0, 0,      ACT_NONE);
      add("allred4",    2, R, R, 0, 0, 0, ALLRED, ACT_NONE);
      add("ns_green2",  0, G, R, 1, 0, 0, 0,      ACT_PED);
      add("ns_yellow2", 1, Y, R, 1, 1, 0, 0,      ACT_NONE);
      add("allred5",    2, R, R, 0, 1, 0, ALLRED, ACT_NONE);
      add("ped_walk1",  5, R, R, 1, 0, 1, 0,      ACT_PED_IGNORE);
      add("allred6",    2, R, R, 0, 0, 0, ALLRED, ACT_NONE);
      add("ew_green2",  3, R, G, 1, 0, 0, 0,      ACT_NONE);

      // Reset state
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_phase",   phase,   2);
      check("rst_ns",      ns,      R);
      check("rst_ew",      ew,      R);
      check("rst_walk",    walk,    0);
      check("rst_waiting", waiting, 0);
      check("rst_ce",      ce,      0);
      timer_on = 1'b1;
      rst = 1'b0;
      dwell(n);
      check("rst_allred_dwell", n, ALLRED);

      // Table-driven walk through the full sequence
      changed = 1'b1;
      for (int i = 0; i < rows.size(); i++) begin
         if (!changed) wait_change(rows[i].name);
         changed = 1'b0;
         check({rows[i].name, "_phase"},   phase,   rows[i].ph);
         check({rows[i].name, "_ns"},      ns,      rows[i].ns);
         check({rows[i].name, "_ew"},      ew,      rows[i].ew);
         check({rows[i].name, "_ce"},      ce,      rows[i].ce);
         check({rows[i].name, "_waiting"}, waiting, rows[i].waiting);
         check({rows[i].name, "_walk"},    walk,    rows[i].walk);
         if (rows[i].dwell > 0) begin
            dwell(n);
            check({rows[i].name, "_dwell"}, n, rows[i].dwell);
            changed = 1'b1;
         end
         case (rows[i].act)
            ACT_PED: begin
               ped_req = 1'b1;
               @(negedge clk);
               ped_req = 1'b0;
               @(negedge clk);
               check({rows[i].name, "_ped_lat2"}, waiting, 0);
               @(negedge clk);
               check({rows[i].name, "_ped_lat3"}, waiting, 1);
            end
            ACT_WALK: begin
               n = 0;
               while (walk && n < 200) begin
                  n++;
                  @(negedge clk);
               end
               check({rows[i].name, "_walk_len"},   n,     60);
               check({rows[i].name, "_walk_phase"}, phase, 5);
            end
            ACT_PED_IGNORE: begin
               ped_req = 1'b1;
               @(negedge clk);
               ped_req = 1'b0;
               repeat (4) @(negedge clk);
               check({rows[i].name, "_no_latch"},    waiting, 0);
               check({rows[i].name, "_still_walk"},  phase,   5);
            end
            default: ;
         endcase
      end

      // Held phase-done across ALL_RED -> NS_GREEN gives no edge
      timer_on = 1'b0;
      @(negedge clk);
      new_state  = 1'b0;
      next_light = 1'b1;
      @(negedge clk);
      check("hold_ew_yellow", phase, 4);
      next_light = 1'b0;
      new_state  = 1'b1;
      @(negedge clk);
      check("hold_allred_entry", phase, 2);
      dwell(n);
      check("hold_allred_dwell", n, ALLRED);
      check("hold_ns_green", phase, 0);
      repeat (20) @(negedge clk);
      check("hold_stays_green", phase, 0);
      next_light = 1'b1;
      @(negedge clk);
      check("hold_nextlight_yellow", phase, 1);

      // Asynchronous reset in the middle of EW_GREEN
      new_state  = 1'b0;
      next_light = 1'b0;
      @(negedge clk);
      new_state = 1'b1;
      @(negedge clk);
      check("mid_allred", phase, 2);
      dwell(n);
      check("mid_allred_dwell", n, ALLRED);
      check("mid_ew_green", phase, 3);
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_ped_pending", waiting, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_ns",      ns,      R);
      check("arst_ew",      ew,      R);
      check("arst_walk",    walk,    0);
      check("arst_ce",      ce,      0);
      check("arst_waiting", waiting, 0);
      check("arst_phase",   phase,   2);
      @(negedge clk);
      new_state = 1'b0;
      rst = 1'b0;
      dwell(n);
      check("arst_allred_dwell", n, ALLRED);
      check("arst_first_green_ns", phase, 0);
      check("arst_no_walk_pending", waiting, 0);

      check("invariant_violations", inv_viol, 0);
      check("enable_violations",    ce_viol,  0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/traffic_light_sequencer.md
Name: traffic_light_sequencer

Overview:
- Light-phase state machine; sits on the other side of the timer handshake.
- Consumes the timer's phase-done (`i_newState`) and go-yellow (`i_nextLight`) indications.
- Drives the timer's count enable, plus the north-south, east-west and pedestrian lamps.
- Sequence: NS green → NS yellow → all-red → (optional pedestrian walk → all-red) → EW green → EW yellow → all-red → NS green → …

Parameters:
- ALLRED_CYCLES, 50000000, length of each all-red interval in i_clk cycles; must be >= 1.
- CNT_W, 26, width of the all-red counter; must satisfy 2^CNT_W >= ALLRED_CYCLES.

Ports:
- i_clk  input  1  system clock.
- i_nreset  input  1  reset; asynchronous, active-high (1 = reset asserted).
- i_newState  input  1  timer phase-done level; only its rising edge is used.
- i_nextLight  input  1  timer go-yellow level; only its rising edge is used.
- i_pedRequest  input  1  asynchronous pedestrian push-button, active-high.
- o_countEnable  output  1  enables the timer to advance.
- o_nsLights  output  3  north-south lamps {red, yellow, green}.
- o_ewLights  output  3  east-west lamps {red, yellow, green}.
- o_pedWalk  output  1  pedestrian WALK lamp.
- o_pedWaiting  output  1  a pedestrian request is latched and not yet served.
- o_phase  output  3  current state code, for debug.

Behaviour:
- Reset (asynchronous, active-high):
  - State ALL_RED, next-direction = NS, all-red counter = 0, pedestrian latch = 0.
  - Edge-detect history flops = 0; synchronizer flops = 0.
  - Outputs during reset: o_nsLights = o_ewLights = 3'b100, o_pedWalk = 0, o_pedWaiting = 0, o_countEnable = 0, o_phase = 2.
- Edge detection:
  - Registered copies of i_newState and i_nextLight.
  - Edge pulse = input & ~previous, valid for one cycle.
  - An input already high when a state is entered produces no edge.
- Pedestrian input path:
  - 2-flop synchronizer, then rising-edge detect.
  - A detected edge sets the latch, except while in PED_WALK, where it is ignored.
  - The latch clears on entry to PED_WALK.
  - o_pedWaiting = latch.
  - Latency from the i_pedRequest rising edge to o_pedWaiting = 1 is 3 clock edges.
- States and codes:
  - NS_GREEN=0, NS_YELLOW=1, ALL_RED=2, EW_GREEN=3, EW_YELLOW=4, PED_WALK=5.
  - Codes 6 and 7 are illegal and go to ALL_RED on the next clock.
- Outputs are a pure decode of the state register, so they change on the same edge as the state.
- Lamp encoding: red = 100, yellow = 010, green = 001.
- NS_GREEN:
  - ns = green, ew = red, countEnable = 1.
  - A rising edge on i_nextLight OR i_newState → NS_YELLOW.
- NS_YELLOW:
  - ns = yellow, ew = red, countEnable = 1.
  - A rising edge on i_newState → ALL_RED, with next-direction = EW.
  - A rising edge on i_nextLight is ignored.
- EW_GREEN / EW_YELLOW: mirror of the NS states; on exit, next-direction = NS.
- ALL_RED:
  - Both directions red, countEnable = 0.
  - The counter clears on entry and increments every cycle.
  - When counter == ALLRED_CYCLES-1 (i.e. exactly ALLRED_CYCLES cycles in state):
    - if the latch is set → PED_WALK;
    - else → NS_GREEN or EW_GREEN according to next-direction.
  - If the latch sets on the final all-red cycle, the walk is taken on that exit.
- PED_WALK:
  - Both directions red, countEnable = 1.
  - o_pedWalk = 1 until the first i_nextLight rising edge in this state, then 0 for the remainder.
  - A rising edge on i_newState → ALL_RED; next-direction is unchanged, so the pending green follows the second all-red.
- Mid-operation reset: immediately all-red and enable low; a pending pedestrian request is discarded.
- Invariant: no cycle in which both directions show a non-red lamp, and o_pedWalk is never 1 unless both directions are red.

Test Plan:
- Reset, then ALLRED_CYCLES=4 with no stimulus:
  - o_phase = 2 for exactly 4 cycles, then 0.
  - ns = 001, ew = 100, countEnable = 1.
- Full cycle (bench timer model: nextLight rises at 6 ticks, newState pulses at 8 ticks, tick = 10 clk):
  - Phase order 0,1,2,3,4,2,0.
  - Each all-red lasts 4 cycles.
  - o_countEnable = 0 only during phase 2.
- Pulse i_pedRequest during NS_GREEN:
  - o_pedWaiting = 1 three edges later.
  - After NS_YELLOW: phases 2 → 5 → 2 → 3.
  - o_pedWalk = 1 in phase 5 until the nextLight rise.
  - o_pedWaiting = 0 from entry to phase 5.
- Press the button during PED_WALK: no new latch; the next phase after the second all-red is 3, not 5.
- Hold i_newState high across ALL_RED → NS_GREEN: no edge, so the state stays 0 until i_nextLight rises.
- Assert i_nreset asynchronously mid-EW_GREEN:
  - Outputs go to red/red, walk 0, enable 0 before the next clock edge.
  - After release, the first green is NS.
